// File: rtl/board_pkg.sv
// Shared board definitions: cell encoding, board dimensions and the memory FSM states.
package board_pkg;

   localparam int unsigned BOARD_X_SIZE       = 12;
   localparam int unsigned BOARD_Y_SIZE       = 12;
   localparam int unsigned BOARD_X_ADDR_WIDTH = 4;
   localparam int unsigned BOARD_Y_ADDR_WIDTH = 4;
   localparam int unsigned BOARD_CELL_WIDTH   = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      SHIP  = 2'd1,
      HIT   = 2'd2,
      MISS  = 2'd3
   } cell_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } board_state_t;

   // Linear cell index with y running fastest, matching the clear sweep order.
   function automatic int unsigned lin_index(input int unsigned x, input int unsigned y,
                                             input int unsigned y_size);
      return x * y_size + y;
   endfunction

endpackage

// File: rtl/board_ram_core.sv
// Plain single-clock RAM: one write port, two registered read-first read ports.
module board_ram_core #(
   parameter int unsigned DataWidth = 2,
   parameter int unsigned Depth     = 144,
   parameter int unsigned AddrWidth = 8
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] waddr_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic [AddrWidth-1:0] ra_addr_i,
   output logic [DataWidth-1:0] ra_data_o,
   input  logic [AddrWidth-1:0] rb_addr_i,
   output logic [DataWidth-1:0] rb_data_o
);

   (* ram_style = "block" *) logic [DataWidth-1:0] mem_q [Depth];

   // Write port plus two read ports; reads return the pre-write contents.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      ra_data_o <= mem_q[ra_addr_i];
      rb_data_o <= mem_q[rb_addr_i];
   end

endmodule

// File: rtl/board_mem_rmw.sv
// Board memory with clear sweep, range checking and a live count of COUNT_VAL cells.
module board_mem_rmw
   import board_pkg::*;
#(
   parameter int unsigned X_SIZE       = BOARD_X_SIZE,
   parameter int unsigned Y_SIZE       = BOARD_Y_SIZE,
   parameter int unsigned X_ADDR_WIDTH = BOARD_X_ADDR_WIDTH,
   parameter int unsigned Y_ADDR_WIDTH = BOARD_Y_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH   = BOARD_CELL_WIDTH,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VAL = DATA_WIDTH'(EMPTY),
   parameter logic [DATA_WIDTH-1:0] COUNT_VAL = DATA_WIDTH'(SHIP),
   parameter int unsigned CNT_WIDTH    = $clog2(X_SIZE * Y_SIZE + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear_req,
   output logic                    busy,
   input  logic                    wr_en,
   input  logic [X_ADDR_WIDTH-1:0] wr_x,
   input  logic [Y_ADDR_WIDTH-1:0] wr_y,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    wr_err,
   input  logic [X_ADDR_WIDTH-1:0] rd_x,
   input  logic [Y_ADDR_WIDTH-1:0] rd_y,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_oob,
   output logic [CNT_WIDTH-1:0]    cell_count,
   output logic                    none_left
);

   localparam int unsigned NumCells = X_SIZE * Y_SIZE;
   localparam int unsigned IdxWidth = $clog2(NumCells);
   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumCells - 1);
   localparam logic [CNT_WIDTH-1:0] ClearCount =
      (CLEAR_VAL == COUNT_VAL) ? CNT_WIDTH'(NumCells) : '0;

   board_state_t          state_q;
   logic [IdxWidth-1:0]   sweep_idx_q;
   logic                  busy_q;
   logic                  sweep_last;

   logic                  wr_in_range;
   logic                  wr_accept;
   logic [IdxWidth-1:0]   wr_lin;
   logic                  pend_valid_q;
   logic [IdxWidth-1:0]   pend_addr_q;
   logic [DATA_WIDTH-1:0] pend_data_q;
   logic                  fwd_valid_q;
   logic [DATA_WIDTH-1:0] fwd_data_q;
   logic [DATA_WIDTH-1:0] old_val;
   logic                  wr_err_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  cnt_d;

   logic                  rd_in_range;
   logic [IdxWidth-1:0]   rd_lin;
   logic                  rd_valid_q;
   logic                  rd_oob_q;
   logic                  rd_busy_q;

   logic                  ram_we;
   logic [IdxWidth-1:0]   ram_waddr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_ra_data;
   logic [DATA_WIDTH-1:0] ram_rb_data;

   assign sweep_last = (state_q == CLEAR) && (sweep_idx_q == LastIdx);

   // Sweep FSM: reset or clear_req starts a one-cell-per-cycle clear over the whole board.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLEAR;
         sweep_idx_q <= '0;
         busy_q      <= 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (clear_req) begin
                  state_q     <= CLEAR;
                  sweep_idx_q <= '0;
                  busy_q      <= 1'b1;
               end
            end
            CLEAR: begin
               if (sweep_last) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  sweep_idx_q <= sweep_idx_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Writes are only taken while idle; a same-cycle clear_req wins over the write.
   assign wr_in_range = (32'(wr_x) < X_SIZE) && (32'(wr_y) < Y_SIZE);
   assign wr_accept   = wr_en && wr_in_range && (state_q == IDLE) && !clear_req;
   assign wr_lin      = wr_in_range ? IdxWidth'(lin_index(32'(wr_x), 32'(wr_y), Y_SIZE)) : '0;

   // Old value comes from the RAM unless the previous write was to the same cell and was
   // committing while this one was being looked up (read-first would miss it).
   assign old_val = fwd_valid_q ? fwd_data_q : ram_rb_data;

   // Counter next state: reload at sweep exit, otherwise adjust by the committing write.
   always_comb begin
      cnt_d = cnt_q;
      if (sweep_last) begin
         cnt_d = ClearCount;
      end else if (pend_valid_q) begin
         if ((pend_data_q == COUNT_VAL) && (old_val != COUNT_VAL)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end else if ((pend_data_q != COUNT_VAL) && (old_val == COUNT_VAL)) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
         end
      end
   end

   // Write pipeline control, error pulse and counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid_q <= 1'b0;
         fwd_valid_q  <= 1'b0;
         wr_err_q     <= 1'b0;
         cnt_q        <= '0;
      end else begin
         pend_valid_q <= wr_accept;
         fwd_valid_q  <= wr_accept && pend_valid_q && (pend_addr_q == wr_lin);
         wr_err_q     <= wr_en && !wr_accept;
         cnt_q        <= cnt_d;
      end
   end

   // Write pipeline payload; qualified by pend_valid_q / fwd_valid_q so no reset needed.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         pend_addr_q <= wr_lin;
         pend_data_q <= wr_data;
         fwd_data_q  <= pend_data_q;
      end
   end

   // The sweep owns the write port while busy; commits never overlap it.
   assign ram_we    = (state_q == CLEAR) || pend_valid_q;
   assign ram_waddr = (state_q == CLEAR) ? sweep_idx_q : pend_addr_q;
   assign ram_wdata = (state_q == CLEAR) ? CLEAR_VAL : pend_data_q;

   assign rd_in_range = (32'(rd_x) < X_SIZE) && (32'(rd_y) < Y_SIZE);
   assign rd_lin      = rd_in_range ? IdxWidth'(lin_index(32'(rd_x), 32'(rd_y), Y_SIZE)) : '0;

   // Read-side qualifiers aligned with the registered RAM output.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_oob_q   <= 1'b0;
         rd_busy_q  <= 1'b0;
      end else begin
         rd_valid_q <= 1'b1;
         rd_oob_q   <= !rd_in_range;
         rd_busy_q  <= busy_q;
      end
   end

   board_ram_core #(
      .DataWidth (DATA_WIDTH),
      .Depth     (NumCells),
      .AddrWidth (IdxWidth)
   ) u_ram (
      .clk_i     (clk),
      .we_i      (ram_we),
      .waddr_i   (ram_waddr),
      .wdata_i   (ram_wdata),
      .ra_addr_i (rd_lin),
      .ra_data_o (ram_ra_data),
      .rb_addr_i (wr_lin),
      .rb_data_o (ram_rb_data)
   );

   assign rd_data    = (!rd_valid_q || rd_oob_q) ? '0 : (rd_busy_q ? CLEAR_VAL : ram_ra_data);
   assign rd_oob     = rd_oob_q;
   assign busy       = busy_q;
   assign wr_err     = wr_err_q;
   assign cell_count = cnt_q;
   assign none_left  = (cnt_q == '0) && !busy_q;

endmodule
